spi_reg_bank: RTL
=================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 The block SHALL have parameter NREGS, default 8, meaning the number of read/write 8-bit registers, legal range 1..32.
REQ-002 The block SHALL have parameter ID_VALUE, default 8'hA5, meaning the constant returned at address 0x00.
REQ-003 The block SHALL have parameter addrsz, default 7, meaning the SPI address width.
REQ-004 The block SHALL have parameter payload, default 8, meaning the data width.
REQ-005 The block SHALL have port clk, input, width 1, meaning the system clock; the block has one clock.
REQ-006 The block SHALL have port reset, input, width 1, meaning reset; reset is synchronous and active-high.
REQ-007 The block SHALL have port addr, input, width addrsz, meaning the register address from the SPI slave.
REQ-008 The block SHALL have port addr_dv, input, width 1, meaning the address is valid; it stays high until the transaction ends.
REQ-009 The block SHALL have port rw_out, input, width 1, meaning the transaction direction: 1 = read, 0 = write.
REQ-010 The block SHALL have port rx_d, input, width payload, meaning the write data from the master.
REQ-011 The block SHALL have port rxdv, input, width 1, meaning write data is valid (level, high until the transaction ends).
REQ-012 The block SHALL have port status_in, input, width payload, meaning live status bits from the system.
REQ-013 The block SHALL have port tx_d, output, width payload, meaning read data to the SPI slave.
REQ-014 The block SHALL have port tx_en, output, width 1, meaning tx_d is valid; the rising edge loads the slave's shifter.
REQ-015 The block SHALL have port regs_out, output, width NREGS*payload, meaning the RW register contents, with register k at bits [8k+7:8k].
REQ-016 The block SHALL have port wr_stb, output, width 1, meaning a one-cycle pulse on each committed RW-register write.
REQ-017 The block SHALL have port wr_addr, output, width addrsz, meaning the address of the last write, valid with wr_stb.

Function
REQ-018 The address map SHALL be: 0x00 ID (RO, ID_VALUE); 0x01 STATUS (RO, status_in registered each clk); 0x02..0x02+NREGS-1 RW registers; 0x7F ERRCNT (RO, write clears); all other addresses unmapped.
REQ-019 The FSM SHALL have states IDLE, RD_HOLD, WR_WAIT and WR_DONE.
REQ-020 In any state, the cycle in which addr_dv is sampled 0 SHALL force the next state to IDLE with tx_en=0 and tx_d=0.
REQ-021 In IDLE, on addr_dv=1 with rw_out=1, the block SHALL on the next clk present tx_d = read mux(addr), set tx_en=1 and enter RD_HOLD (latency 1 cycle).
REQ-022 In IDLE, on addr_dv=1 with rw_out=0, the block SHALL enter WR_WAIT.
REQ-023 In RD_HOLD, tx_d and tx_en SHALL hold constant until addr_dv falls; a register update during RD_HOLD SHALL NOT alter tx_d.
REQ-024 In WR_WAIT, on rxdv=1, the block SHALL commit rx_d to the addressed RW register on the next clk, pulse wr_stb for exactly 1 cycle with wr_addr=addr, and enter WR_DONE.
REQ-025 In WR_DONE, the block SHALL ignore rxdv and perform no further write until IDLE is re-entered (one write per transaction).
REQ-026 Writes to ID or STATUS SHALL be ignored, with no wr_stb pulse.
REQ-027 A write to ERRCNT SHALL clear it to 0, with no wr_stb pulse.
REQ-028 Unmapped reads SHALL return 8'h00.
REQ-029 Unmapped reads and writes SHALL increment ERRCNT once per transaction, saturating at 8'hFF; unmapped writes produce no wr_stb pulse.
REQ-030 rxdv=1 while addr_dv=0 SHALL be ignored.

Reset
REQ-031 While reset=1 at a clk edge, the block SHALL set state=IDLE, tx_d=0, tx_en=0, wr_stb=0, wr_addr=0, regs_out=0, ERRCNT=0 and STATUS=0.
REQ-032 Reset asserted mid-transaction SHALL take priority over all FSM activity and discard any pending write.

Structure
REQ-033 A shared package spi_pkg SHALL hold the FSM state enum and the address constants (ADDR_ID=0x00, ADDR_STATUS=0x01, ADDR_RW_BASE=0x02, ADDR_ERRCNT=0x7F).
REQ-034 The read mux and address decode SHALL be one sub-module, spi_reg_decode (combinational: addr -> rd_data, is_rw, is_ro, is_err, is_unmapped); the FSM and storage stay in spi_reg_bank.

Verification
REQ-035 Read ID: addr_dv 0->1 with addr=0x00, rw_out=1 -> tx_d=8'hA5 and tx_en=1 one cycle later, held until addr_dv=0, then both 0.
REQ-036 Write/readback: write addr=0x03, rx_d=8'h5C -> wr_stb pulses 1 cycle, wr_addr=0x03, regs_out[15:8]=8'h5C; a later read of 0x03 returns 8'h5C.
REQ-037 Unmapped: read 0x40, then write 0x50 -> tx_d=8'h00, no wr_stb, ERRCNT=2; a write of 0x7F clears ERRCNT, and a read then returns 8'h00.
REQ-038 Saturation: 300 unmapped transactions -> ERRCNT reads 8'hFF.
REQ-039 RO protect and single write: write 0x01, then a write transaction to 0x02 with rxdv held high for 20 cycles -> STATUS unaffected, exactly one wr_stb pulse.
REQ-040 Reset mid-read: assert reset during RD_HOLD -> next cycle tx_en=0, tx_d=0, regs_out=0, state IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: FSM states and the fixed address map.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_HOLD = 2'd1,
    WR_WAIT = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  localparam int ADDR_ID      = 'h00;
  localparam int ADDR_STATUS  = 'h01;
  localparam int ADDR_RW_BASE = 'h02;
  localparam int ADDR_ERRCNT  = 'h7F;

endpackage

// File: rtl/spi_reg_decode.sv
// Combinational address decode and read mux for the SPI register bank.
module spi_reg_decode
  import spi_pkg::*;
#(
  parameter int         NREGS    = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int         addrsz   = 7,
  parameter int         payload  = 8
) (
  input  logic [addrsz-1:0]        addr,
  input  logic [NREGS*payload-1:0] regs,
  input  logic [payload-1:0]       status,
  input  logic [payload-1:0]       errcnt,
  output logic [payload-1:0]       rd_data,
  output logic                     is_rw,
  output logic                     is_ro,
  output logic                     is_err,
  output logic                     is_unmapped,
  output logic [NREGS-1:0]         rw_sel
);

  int a;
  assign a = int'(addr);

  // rw_sel is one-hot over the RW window; unmapped addresses read as zero
  always_comb begin
    rd_data = '0;
    rw_sel  = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (a == ADDR_RW_BASE + k) begin
        rw_sel[k] = 1'b1;
        rd_data   = regs[k*payload +: payload];
      end
    end
    is_rw       = |rw_sel;
    is_ro       = (a == ADDR_ID) || (a == ADDR_STATUS);
    is_err      = (a == ADDR_ERRCNT);
    is_unmapped = !(is_rw || is_ro || is_err);
    if (a == ADDR_ID)
      rd_data = payload'(ID_VALUE);
    else if (a == ADDR_STATUS)
      rd_data = status;
    else if (is_err)
      rd_data = errcnt;
  end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: ID, live STATUS, NREGS RW registers and a saturating error counter.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int         NREGS    = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int         addrsz   = 7,
  parameter int         payload  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [addrsz-1:0]        addr,
  input  logic                     addr_dv,
  input  logic                     rw_out,
  input  logic [payload-1:0]       rx_d,
  input  logic                     rxdv,
  input  logic [payload-1:0]       status_in,
  output logic [payload-1:0]       tx_d,
  output logic                     tx_en,
  output logic [NREGS*payload-1:0] regs_out,
  output logic                     wr_stb,
  output logic [addrsz-1:0]        wr_addr
);

  state_t               state;
  logic [payload-1:0]   status_reg;
  logic [payload-1:0]   errcnt;
  logic [payload-1:0]   rd_data;
  logic                 is_rw, is_ro, is_err, is_unmapped;
  logic [NREGS-1:0]     rw_sel;

  spi_reg_decode #(
    .NREGS   (NREGS),
    .ID_VALUE(ID_VALUE),
    .addrsz  (addrsz),
    .payload (payload)
  ) u_decode (
    .addr       (addr),
    .regs       (regs_out),
    .status     (status_reg),
    .errcnt     (errcnt),
    .rd_data    (rd_data),
    .is_rw      (is_rw),
    .is_ro      (is_ro),
    .is_err     (is_err),
    .is_unmapped(is_unmapped),
    .rw_sel     (rw_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx_d       <= '0;
      tx_en      <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      regs_out   <= '0;
      errcnt     <= '0;
      status_reg <= '0;
    end else begin
      status_reg <= status_in;
      wr_stb     <= 1'b0;
      // Dropping addr_dv ends the transaction from any state
      if (!addr_dv) begin
        state <= IDLE;
        tx_en <= 1'b0;
        tx_d  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rw_out) begin
              tx_d  <= rd_data;
              tx_en <= 1'b1;
              state <= RD_HOLD;
              if (is_unmapped && errcnt != {payload{1'b1}})
                errcnt <= errcnt + payload'(1);
            end else begin
              state <= WR_WAIT;
            end
          end
          RD_HOLD: ;
          WR_WAIT: begin
            if (rxdv) begin
              state <= WR_DONE;
              if (is_rw) begin
                for (int k = 0; k < NREGS; k++)
                  if (rw_sel[k]) regs_out[k*payload +: payload] <= rx_d;
                wr_stb  <= 1'b1;
                wr_addr <= addr;
              end else if (is_err) begin
                errcnt <= '0;
              end else if (!is_ro && errcnt != {payload{1'b1}}) begin
                errcnt <= errcnt + payload'(1);
              end
            end
          end
          WR_DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
